obstacle_scheduler: RTL and testbench
=====================================

Name: obstacle_scheduler

Overview:
- Owns the obstacle slots of the T-rex runner: spawns, scrolls and retires up to NUM_SLOTS obstacles, one step per frame tick.
- Derives scroll speed from the running score.
- Sits between the rex FSM/score logic and the pixel renderer; renderer and collision logic consume obs_x/obs_active/obs_type.
- A single shared subtract/compare datapath is time-multiplexed across the slots by an internal sequencer.

Parameters:
- NUM_SLOTS, 3: number of obstacle slots.
- SCREEN_W, 640: visible width in pixels.
- OBS_W, 20: obstacle width; spawn x = SCREEN_W+OBS_W-1.
- MIN_GAP, 160: minimum pixel distance between spawns.
- RAND_MASK, 7'h7F: mask on the LFSR-derived extra gap.
- SPEED_INIT, 2: pixels per tick after restart.
- SPEED_MAX, 8: speed ceiling.
- SPEED_STEP_PTS, 100: score points per speed increment.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- ClkPort  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle frame strobe.
- run  in  1  game running; ticks are ignored when low.
- restart  in  1  synchronous clear of game state.
- score  in  16  current score.
- obs_x  out  NUM_SLOTS*10  packed right-edge x per slot; slot i occupies bits [10i+9:10i].
- obs_active  out  NUM_SLOTS  slot valid.
- obs_type  out  NUM_SLOTS*2  packed obstacle type.
- speed  out  4  current scroll speed.
- spawn  out  1  one-cycle pulse when a slot is filled.
- frame_done  out  1  one-cycle pulse when a tick's update completes.

Behaviour:
Reset values:
- All outputs 0, except speed = SPEED_INIT.
- State IDLE; gap_cnt = 0; threshold = SPEED_STEP_PTS; lfsr = LFSR_SEED.

States:
- IDLE: on tick && run, go to UPDATE with idx = 0. Otherwise hold. tick while run = 0 is dropped.
- UPDATE: one slot per cycle, idx 0..NUM_SLOTS-1.
  - Active slot with x <= step: active <= 0, x <= 0 (retire).
  - Active slot otherwise: x <= x - step.
  - Inactive slot: untouched.
  - step = speed, or speed+1 for birds (see Optional Feature).
  - After the last idx, go to SPAWN.
- SPAWN:
  - gap_cnt <= min(gap_cnt + speed, 1023).
  - Spawn if the pre-update gap_cnt >= MIN_GAP + (lfsr[6:0] & RAND_MASK) and at least one slot is free.
  - On spawn, fill the lowest-index free slot: x = SCREEN_W+OBS_W-1, type from lfsr[9:8], active = 1. Set gap_cnt <= 0 and pulse spawn.
  - No free slot: spawn is deferred and gap_cnt keeps saturating.
  - The LFSR (x^16+x^14+x^13+x^11) advances exactly once per SPAWN state, whether or not a spawn occurs.
  - Go to IDLE and pulse frame_done.

Latency:
- Tick sampled in IDLE at cycle T.
- Slot i updated at the edge ending cycle T+1+i.
- spawn and frame_done asserted in cycle T+NUM_SLOTS+1.
- Outputs stable from T+NUM_SLOTS+2.

Tick handling:
- tick arriving while not IDLE is ignored; no queueing.

Speed:
- Evaluated only in IDLE, one increment per cycle maximum.
- If score >= threshold and speed < SPEED_MAX: speed++ and threshold += SPEED_STEP_PTS.
- At SPEED_MAX the threshold stops advancing.

restart:
- Highest priority; takes effect at the clock edge regardless of state, including mid-UPDATE.
- Clears all slots (x = 0, active = 0, type = 0), gap_cnt, speed = SPEED_INIT and threshold = SPEED_STEP_PTS.
- Forces IDLE, with no spawn or frame_done pulse.
- Does not reset the LFSR, so successive games differ.

Reset asserted mid-operation returns everything to reset values immediately.

Widths:
- The x subtraction is 10-bit and never wraps, because of the x <= step retire rule.
- threshold is 17-bit so score 0xFFFF cannot overflow it.

Optional Feature:
OBS_BIRD_EN
- Defined: type 3 = bird. Birds scroll at speed+1 and retire when x <= speed+1.
- Undefined: lfsr[9:8] = 3 is remapped to type 1. Types stay within 0..2 and all slots scroll at speed.

Test Plan:
- Reset, then 1 tick with run = 1, RAND_MASK = 0, MIN_GAP = 0 -> spawn pulse in cycle T+4; slot0 active with x = 659; speed = 2; frame_done at T+4.
- Continue ticks with RAND_MASK = 0, MIN_GAP = 160 -> slot0 x decreases by 2 per tick; next spawn on the 81st tick after the first spawn (gap 160 reached), into slot1.
- Fill all 3 slots with MIN_GAP = 0 -> 4th tick gives no spawn and gap_cnt grows; the retire of slot0 at x <= 2 frees it and the next tick refills slot0.
- Raise score 0 -> 350 while idle -> speed steps 2→3→4→5 on successive idle cycles; score 1000 -> speed saturates at 8.
- restart asserted during UPDATE (idx = 1) -> next cycle: all obs_active = 0, speed = 2, no frame_done; LFSR value not reset.
- tick with run = 0, and a second tick arriving during UPDATE -> both ignored; positions unchanged; exactly one frame_done per accepted tick.

Source files
------------

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler
// Owns the obstacle slots of the T-rex runner. On each accepted frame tick
// it scrolls every active slot left by one step, retires slots that reach
// the left edge, and may spawn a new obstacle into the lowest free slot.
// Scroll speed is derived from the running score while idle.
//
// Ports:
//   ClkPort     system clock
//   Reset       asynchronous, active-high reset
//   tick        one-cycle frame strobe (ignored unless idle and run=1)
//   run         game running
//   restart     synchronous clear of game state (LFSR is kept)
//   score       current score
//   obs_x       packed right-edge x per slot, slot i at [10i+9:10i]
//   obs_active  slot valid flags
//   obs_type    packed 2-bit obstacle type per slot
//   speed       current scroll speed
//   spawn       one-cycle pulse in the cycle a slot is filled
//   frame_done  one-cycle pulse in the cycle a tick's update completes
//
// Build option: define OBS_BIRD_EN to enable type 3 (bird), which scrolls
// at speed+1. Without it, type 3 is remapped to type 1.

module obstacle_scheduler #(
  parameter int unsigned NUM_SLOTS      = 3,
  parameter int unsigned SCREEN_W       = 640,
  parameter int unsigned OBS_W          = 20,
  parameter int unsigned MIN_GAP        = 160,
  parameter logic [6:0]  RAND_MASK      = 7'h7F,
  parameter int unsigned SPEED_INIT     = 2,
  parameter int unsigned SPEED_MAX      = 8,
  parameter int unsigned SPEED_STEP_PTS = 100,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic                     ClkPort,
  input  logic                     Reset,
  input  logic                     tick,
  input  logic                     run,
  input  logic                     restart,
  input  logic [15:0]              score,
  output logic [NUM_SLOTS*10-1:0]  obs_x,
  output logic [NUM_SLOTS-1:0]     obs_active,
  output logic [NUM_SLOTS*2-1:0]   obs_type,
  output logic [3:0]               speed,
  output logic                     spawn,
  output logic                     frame_done
);

  localparam int unsigned        IDX_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [9:0]         SPAWN_X  = 10'(SCREEN_W + OBS_W - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SLOTS - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_UPDATE, ST_SPAWN} state_t;

  state_t               state;
  logic [IDX_W-1:0]     idx;
  logic [9:0]           x_q [NUM_SLOTS];
  logic [1:0]           type_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] act_q;
  logic [9:0]           gap_cnt;
  logic [16:0]          threshold;
  logic [15:0]          lfsr;

  // Shared per-slot datapath, steered by idx
  logic [9:0]           cur_x;
  logic [4:0]           step;
  logic                 retire;
  logic [9:0]           x_next;
  logic [NUM_SLOTS-1:0] act_after;
  logic [10:0]          gap_need;
  logic                 gap_ok;
  logic [10:0]          gap_sum;
  logic [9:0]           gap_sat;
  logic [IDX_W-1:0]     free_idx;
  logic [1:0]           new_type;
  logic [15:0]          lfsr_next;
  logic                 speed_up;

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
    assign obs_x[g*10 +: 10] = x_q[g];
    assign obs_type[g*2 +: 2] = type_q[g];
  end
  assign obs_active = act_q;

  always_comb begin
    cur_x = x_q[idx];
`ifdef OBS_BIRD_EN
    step = (type_q[idx] == 2'd3) ? ({1'b0, speed} + 5'd1) : {1'b0, speed};
`else
    step = {1'b0, speed};
`endif
    retire = act_q[idx] && (cur_x <= {5'd0, step});
    x_next = cur_x - {5'd0, step};

    // Free-slot test must see the retire happening on the last UPDATE edge,
    // because the spawn decision is registered on that same edge.
    act_after = act_q;
    if (retire) act_after[idx] = 1'b0;

    gap_need = 11'(MIN_GAP) + {4'd0, lfsr[6:0] & RAND_MASK};
    gap_ok   = ({1'b0, gap_cnt} >= gap_need);
    gap_sum  = {1'b0, gap_cnt} + {7'd0, speed};
    gap_sat  = gap_sum[10] ? '1 : gap_sum[9:0];

    free_idx = '0;
    for (int unsigned i = NUM_SLOTS; i > 0; i--) begin
      if (!act_q[IDX_W'(i - 1)]) free_idx = IDX_W'(i - 1);
    end

    new_type = lfsr[9:8];
`ifndef OBS_BIRD_EN
    if (new_type == 2'd3) new_type = 2'd1;
`endif

    lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    speed_up  = ({1'b0, score} >= threshold) && (speed < 4'(SPEED_MAX));
  end

  always_ff @(posedge ClkPort or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      x_q        <= '{default: '0};
      type_q     <= '{default: '0};
      act_q      <= '0;
      gap_cnt    <= '0;
      threshold  <= 17'(SPEED_STEP_PTS);
      lfsr       <= LFSR_SEED;
      speed      <= 4'(SPEED_INIT);
      spawn      <= 1'b0;
      frame_done <= 1'b0;
    end else if (restart) begin
      state      <= ST_IDLE;
      idx        <= '0;
      x_q        <= '{default: '0};
      type_q     <= '{default: '0};
      act_q      <= '0;
      gap_cnt    <= '0;
      threshold  <= 17'(SPEED_STEP_PTS);
      speed      <= 4'(SPEED_INIT);
      spawn      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          spawn      <= 1'b0;
          frame_done <= 1'b0;
          if (speed_up) begin
            speed     <= speed + 4'd1;
            threshold <= threshold + 17'(SPEED_STEP_PTS);
          end
          if (tick && run) begin
            state <= ST_UPDATE;
            idx   <= '0;
          end
        end
        ST_UPDATE: begin
          if (act_q[idx]) begin
            if (retire) begin
              act_q[idx] <= 1'b0;
              x_q[idx]   <= '0;
            end else begin
              x_q[idx] <= x_next;
            end
          end
          if (idx == LAST_IDX) begin
            // Pulses are registered here so they are visible during SPAWN.
            state      <= ST_SPAWN;
            spawn      <= gap_ok && !(&act_after);
            frame_done <= 1'b1;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        ST_SPAWN: begin
          if (spawn) begin
            x_q[free_idx]    <= SPAWN_X;
            type_q[free_idx] <= new_type;
            act_q[free_idx]  <= 1'b1;
            gap_cnt          <= '0;
          end else begin
            gap_cnt <= gap_sat;
          end
          lfsr       <= lfsr_next;
          spawn      <= 1'b0;
          frame_done <= 1'b0;
          state      <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Testbench for obstacle_scheduler. Instance a uses MIN_GAP=0/RAND_MASK=0
// (spawn whenever a slot is free); instance b uses MIN_GAP=160/RAND_MASK=0
// to exercise gap spacing. Built without OBS_BIRD_EN.

module tb_obstacle_scheduler;

  logic        clk;
  logic        rst;

  logic        tick_a, run_a, restart_a;
  logic [15:0] score_a;
  logic [29:0] obs_x_a;
  logic [2:0]  obs_active_a;
  logic [5:0]  obs_type_a;
  logic [3:0]  speed_a;
  logic        spawn_a, frame_done_a;

  logic        tick_b, run_b, restart_b;
  logic [15:0] score_b;
  logic [29:0] obs_x_b;
  logic [2:0]  obs_active_b;
  logic [5:0]  obs_type_b;
  logic [3:0]  speed_b;
  logic        spawn_b, frame_done_b;

  int unsigned checks;
  int unsigned errors;
  logic [15:0] lfsr_a;

  obstacle_scheduler #(.MIN_GAP(0), .RAND_MASK(7'h00)) dut_a (
    .ClkPort(clk), .Reset(rst), .tick(tick_a), .run(run_a), .restart(restart_a),
    .score(score_a), .obs_x(obs_x_a), .obs_active(obs_active_a), .obs_type(obs_type_a),
    .speed(speed_a), .spawn(spawn_a), .frame_done(frame_done_a)
  );

  obstacle_scheduler #(.MIN_GAP(160), .RAND_MASK(7'h00)) dut_b (
    .ClkPort(clk), .Reset(rst), .tick(tick_b), .run(run_b), .restart(restart_b),
    .score(score_b), .obs_x(obs_x_b), .obs_active(obs_active_b), .obs_type(obs_type_b),
    .speed(speed_b), .spawn(spawn_b), .frame_done(frame_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // x^16+x^14+x^13+x^11 Fibonacci LFSR, shifted left
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    lfsr_step = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [1:0] type_of(input logic [15:0] l);
    type_of = (l[9:8] == 2'd3) ? 2'd1 : l[9:8];
  endfunction

  // Called at a negedge with the DUT idle. Returns the frame_done and spawn
  // values seen mid-cycle in T+1..T+4 (bit 3 = T+4); ends mid T+5.
  task automatic do_tick(input int unsigned sel, input int unsigned hold,
                         output logic [3:0] fdb, output logic [3:0] spb);
    if (sel == 0) tick_a = 1'b1; else tick_b = 1'b1;
    @(negedge clk);
    for (int unsigned c = 0; c < 4; c++) begin
      if (c + 1 >= hold) begin
        tick_a = 1'b0;
        tick_b = 1'b0;
      end
      fdb[c] = (sel == 0) ? frame_done_a : frame_done_b;
      spb[c] = (sel == 0) ? spawn_a : spawn_b;
      @(negedge clk);
    end
    if (sel == 0) lfsr_a = lfsr_step(lfsr_a);
  endtask

  logic [3:0]  fdb, spb;
  logic [1:0]  et;
  int unsigned bad, seen;

  initial begin
    checks = 0; errors = 0;
    lfsr_a = 16'hACE1;
    tick_a = 0; run_a = 1; restart_a = 0; score_a = 0;
    tick_b = 0; run_b = 1; restart_b = 0; score_b = 0;
    rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);

    check_val("rst_x",      32'(obs_x_a), 32'd0);
    check_val("rst_active", 32'(obs_active_a), 32'd0);
    check_val("rst_type",   32'(obs_type_a), 32'd0);
    check_val("rst_speed",  32'(speed_a), 32'd2);
    check_val("rst_pulses", {30'd0, spawn_a, frame_done_a}, 32'd0);
    check_val("rst_b",      {obs_active_b, speed_b, spawn_b, frame_done_b}, {3'd0, 4'd2, 2'd0});

    // First tick: immediate spawn into slot0
    et = type_of(lfsr_a);
    do_tick(0, 1, fdb, spb);
    check_val("t1_fd",     32'(fdb), 32'b1000);
    check_val("t1_spawn",  32'(spb), 32'b1000);
    check_val("t1_x",      32'(obs_x_a), {2'd0, 10'd0, 10'd0, 10'd659});
    check_val("t1_active", 32'(obs_active_a), 32'b001);
    check_val("t1_type",   32'(obs_type_a[1:0]), 32'(et));
    check_val("t1_speed",  32'(speed_a), 32'd2);

    et = type_of(lfsr_a);
    do_tick(0, 1, fdb, spb);
    check_val("t2_spawn",  32'(spb), 32'b1000);
    check_val("t2_x",      32'(obs_x_a), {2'd0, 10'd0, 10'd659, 10'd657});
    check_val("t2_active", 32'(obs_active_a), 32'b011);
    check_val("t2_type",   32'(obs_type_a[3:2]), 32'(et));

    et = type_of(lfsr_a);
    do_tick(0, 1, fdb, spb);
    check_val("t3_x",      32'(obs_x_a), {2'd0, 10'd659, 10'd657, 10'd655});
    check_val("t3_active", 32'(obs_active_a), 32'b111);
    check_val("t3_type",   32'(obs_type_a[5:4]), 32'(et));

    // All slots full: no spawn
    do_tick(0, 1, fdb, spb);
    check_val("full_fd",    32'(fdb), 32'b1000);
    check_val("full_spawn", 32'(spb), 32'b0000);
    check_val("full_x",     32'(obs_x_a), {2'd0, 10'd657, 10'd655, 10'd653});

    // tick with run low is dropped
    run_a = 0;
    tick_a = 1;
    @(negedge clk);
    tick_a = 0;
    seen = 0;
    repeat (6) begin
      if (frame_done_a) seen++;
      @(negedge clk);
    end
    run_a = 1;
    check_val("norun_fd", seen, 0);
    check_val("norun_x",  32'(obs_x_a), {2'd0, 10'd657, 10'd655, 10'd653});

    // tick held into UPDATE: only one frame processed
    do_tick(0, 2, fdb, spb);
    seen = 0;
    repeat (5) begin
      if (frame_done_a) seen++;
      @(negedge clk);
    end
    check_val("dup_fd",    32'(fdb), 32'b1000);
    check_val("dup_extra", seen, 0);
    check_val("dup_x",     32'(obs_x_a), {2'd0, 10'd655, 10'd653, 10'd651});

    // Ticks 6..330: slots stay full, no spawns
    bad = 0;
    for (int i = 6; i <= 330; i++) begin
      do_tick(0, 1, fdb, spb);
      if (fdb !== 4'b1000 || spb !== 4'b0000) bad++;
    end
    check_val("bulk_a", bad, 0);

    // Tick 331: slot0 (x=1) retires and is refilled in the same frame
    et = type_of(lfsr_a);
    do_tick(0, 1, fdb, spb);
    check_val("refill_spawn",  32'(spb), 32'b1000);
    check_val("refill_x",      32'(obs_x_a), {2'd0, 10'd3, 10'd1, 10'd659});
    check_val("refill_active", 32'(obs_active_a), 32'b111);
    check_val("refill_type",   32'(obs_type_a[1:0]), 32'(et));

    // Speed from score, one step per idle cycle
    score_a = 16'd350;
    @(negedge clk); check_val("spd_350_a", 32'(speed_a), 32'd3);
    @(negedge clk); check_val("spd_350_b", 32'(speed_a), 32'd4);
    @(negedge clk); check_val("spd_350_c", 32'(speed_a), 32'd5);
    @(negedge clk); check_val("spd_350_d", 32'(speed_a), 32'd5);
    score_a = 16'd1000;
    @(negedge clk); check_val("spd_1k_a", 32'(speed_a), 32'd6);
    @(negedge clk); check_val("spd_1k_b", 32'(speed_a), 32'd7);
    @(negedge clk); check_val("spd_1k_c", 32'(speed_a), 32'd8);
    @(negedge clk); check_val("spd_1k_d", 32'(speed_a), 32'd8);

    // Speed 8: slots 1 and 2 retire, lowest free (slot1) refilled
    et = type_of(lfsr_a);
    do_tick(0, 1, fdb, spb);
    check_val("fast_spawn",  32'(spb), 32'b1000);
    check_val("fast_x",      32'(obs_x_a), {2'd0, 10'd0, 10'd659, 10'd651});
    check_val("fast_active", 32'(obs_active_a), 32'b011);
    check_val("fast_type",   32'(obs_type_a[3:2]), 32'(et));

    // restart while UPDATE is on idx 1; frame never reaches SPAWN
    tick_a = 1;
    @(negedge clk);
    tick_a = 0;
    @(negedge clk);
    restart_a = 1;
    score_a = 0;
    @(negedge clk);
    restart_a = 0;
    check_val("rs_x",      32'(obs_x_a), 32'd0);
    check_val("rs_active", 32'(obs_active_a), 32'd0);
    check_val("rs_type",   32'(obs_type_a), 32'd0);
    check_val("rs_speed",  32'(speed_a), 32'd2);
    check_val("rs_pulses", {30'd0, spawn_a, frame_done_a}, 32'd0);
    @(negedge clk);
    check_val("rs_fd_late", {30'd0, spawn_a, frame_done_a}, 32'd0);

    // First game frame after restart; LFSR continues from before
    et = type_of(lfsr_a);
    do_tick(0, 1, fdb, spb);
    check_val("rs_t1_spawn", 32'(spb), 32'b1000);
    check_val("rs_t1_x",     32'(obs_x_a), {2'd0, 10'd0, 10'd0, 10'd659});
    check_val("rs_t1_type",  32'(obs_type_a[1:0]), 32'(et));

    // Instance b: gap 160 at speed 2 needs 80 silent ticks
    bad = 0;
    for (int n = 1; n <= 80; n++) begin
      do_tick(1, 1, fdb, spb);
      if (fdb !== 4'b1000 || spb !== 4'b0000) bad++;
    end
    check_val("gap_wait", bad, 0);
    do_tick(1, 1, fdb, spb);
    check_val("gap_first",   32'(spb), 32'b1000);
    check_val("gap_first_x", 32'(obs_x_b), {2'd0, 10'd0, 10'd0, 10'd659});
    bad = 0;
    for (int m = 1; m <= 80; m++) begin
      do_tick(1, 1, fdb, spb);
      if (spb !== 4'b0000 || obs_x_b[9:0] !== 10'(659 - 2 * m)) bad++;
    end
    check_val("gap_scroll", bad, 0);
    do_tick(1, 1, fdb, spb);
    check_val("gap_second",   32'(spb), 32'b1000);
    check_val("gap_second_x", 32'(obs_x_b), {2'd0, 10'd0, 10'd659, 10'd497});
    check_val("gap_second_a", 32'(obs_active_b), 32'b011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
